// File: rtl/cpu7_ifu_dec_queue.sv
// Fetch-to-decode packet queue: DEPTH entries, a push is visible at the head one cycle later (no fall-through).
// Backpressure: dec_fdp_ready drops only on registered full (no full-bypass); exu_ifu_ready stalls the head.
module cpu7_ifu_dec_queue #(
  parameter int          GRLEN        = 32,
  parameter int          DEPTH        = 4,
  parameter int          HINT_W       = 8,
  parameter logic [5:0]  EXC_INT_CODE = 6'h00
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         fdp_dec_valid,
  output logic                         dec_fdp_ready,
  input  logic [GRLEN-1:0]             fdp_dec_pc,
  input  logic [31:0]                  fdp_dec_inst,
  input  logic [GRLEN-3:0]             fdp_dec_br_target,
  input  logic                         fdp_dec_br_taken,
  input  logic                         fdp_dec_exception,
  input  logic [5:0]                   fdp_dec_exccode,
  input  logic [HINT_W-1:0]            fdp_dec_hint,
  input  logic                         exu_ifu_ready,
  input  logic                         exu_ifu_flush,
  input  logic                         int_except,
  output logic                         ifu_exu_valid_d,
  output logic [GRLEN-1:0]             ifu_exu_pc_d,
  output logic [31:0]                  ifu_exu_inst_d,
  output logic [GRLEN-3:0]             ifu_exu_br_target_d,
  output logic                         ifu_exu_br_taken_d,
  output logic                         ifu_exu_exception_d,
  output logic [5:0]                   ifu_exu_exccode_d,
  output logic [HINT_W-1:0]            ifu_exu_hint_d,
  output logic [$clog2(DEPTH+1)-1:0]   dec_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [GRLEN-1:0]  pc;
    logic [31:0]       inst;
    logic [GRLEN-3:0]  br_target;
    logic              br_taken;
    logic              exception;
    logic [5:0]        exccode;
    logic [HINT_W-1:0] hint;
  } pkt_t;

  pkt_t          mem_q [DEPTH];
  pkt_t          wr_pkt;
  pkt_t          head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign dec_fdp_ready   = (count_q != FULL);
  assign ifu_exu_valid_d = (count_q != '0);
  assign dec_count       = count_q;

  assign push = fdp_dec_valid & dec_fdp_ready & ~exu_ifu_flush;
  assign pop  = ifu_exu_valid_d & exu_ifu_ready & ~exu_ifu_flush;

  assign wr_pkt = '{pc: fdp_dec_pc, inst: fdp_dec_inst, br_target: fdp_dec_br_target,
                    br_taken: fdp_dec_br_taken, exception: fdp_dec_exception,
                    exccode: fdp_dec_exccode, hint: fdp_dec_hint};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (exu_ifu_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the head is masked by valid instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_pkt;
  end

  assign head = mem_q[rd_ptr_q];

  assign ifu_exu_pc_d        = ifu_exu_valid_d ? head.pc        : '0;
  assign ifu_exu_inst_d      = ifu_exu_valid_d ? head.inst      : '0;
  assign ifu_exu_br_target_d = ifu_exu_valid_d ? head.br_target : '0;
  assign ifu_exu_br_taken_d  = ifu_exu_valid_d & head.br_taken;
  assign ifu_exu_hint_d      = ifu_exu_valid_d ? head.hint      : '0;

  // Interrupt is tagged onto the head combinationally and never written back.
  assign ifu_exu_exception_d = ifu_exu_valid_d & (head.exception | int_except);
  always_comb begin
    ifu_exu_exccode_d = 6'd0;
    if (ifu_exu_valid_d) begin
      if (int_except)          ifu_exu_exccode_d = EXC_INT_CODE;
      else if (head.exception) ifu_exu_exccode_d = head.exccode;
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_dec_queue.sv
// Randomized and directed stimulus against a packet-queue reference model with a negedge monitor.
module tb_cpu7_ifu_dec_queue;
  localparam int         GRLEN        = 32;
  localparam int         DEPTH        = 4;
  localparam int         HINT_W       = 8;
  localparam logic [5:0] EXC_INT_CODE = 6'h00;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [29:0] tgt;
    logic        taken;
    logic        exc;
    logic [5:0]  code;
    logic [7:0]  hint;
  } pkt_s;

  logic        clk, resetn;
  logic        fdp_dec_valid, dec_fdp_ready;
  logic        exu_ifu_ready, exu_ifu_flush, int_except;
  logic        ifu_exu_valid_d, ifu_exu_br_taken_d, ifu_exu_exception_d;
  logic [31:0] ifu_exu_pc_d, ifu_exu_inst_d;
  logic [29:0] ifu_exu_br_target_d;
  logic [5:0]  ifu_exu_exccode_d;
  logic [7:0]  ifu_exu_hint_d;
  logic [2:0]  dec_count;

  pkt_s cur;
  pkt_s exp_q[$];
  int   checks = 0;
  int   failures = 0;

  cpu7_ifu_dec_queue #(.GRLEN(GRLEN), .DEPTH(DEPTH), .HINT_W(HINT_W), .EXC_INT_CODE(EXC_INT_CODE)) dut (
    .clk(clk), .resetn(resetn),
    .fdp_dec_valid(fdp_dec_valid), .dec_fdp_ready(dec_fdp_ready),
    .fdp_dec_pc(cur.pc), .fdp_dec_inst(cur.inst), .fdp_dec_br_target(cur.tgt),
    .fdp_dec_br_taken(cur.taken), .fdp_dec_exception(cur.exc), .fdp_dec_exccode(cur.code),
    .fdp_dec_hint(cur.hint),
    .exu_ifu_ready(exu_ifu_ready), .exu_ifu_flush(exu_ifu_flush), .int_except(int_except),
    .ifu_exu_valid_d(ifu_exu_valid_d), .ifu_exu_pc_d(ifu_exu_pc_d), .ifu_exu_inst_d(ifu_exu_inst_d),
    .ifu_exu_br_target_d(ifu_exu_br_target_d), .ifu_exu_br_taken_d(ifu_exu_br_taken_d),
    .ifu_exu_exception_d(ifu_exu_exception_d), .ifu_exu_exccode_d(ifu_exu_exccode_d),
    .ifu_exu_hint_d(ifu_exu_hint_d), .dec_count(dec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pkt_s mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic exc, input logic [5:0] code);
    pkt_s p;
    p.pc = pc; p.inst = inst; p.tgt = 30'(pc >> 2) + 30'd3; p.taken = pc[2];
    p.exc = exc; p.code = code; p.hint = pc[9:2] ^ 8'h5a;
    return p;
  endfunction

  function automatic pkt_s rnd_pkt();
    pkt_s p;
    p.pc = $urandom; p.inst = $urandom; p.tgt = 30'($urandom); p.taken = 1'($urandom);
    p.exc = ($urandom_range(0, 3) == 0); p.code = 6'($urandom); p.hint = 8'($urandom);
    return p;
  endfunction

  // Inputs change 2 time units after the rising edge and hold for one cycle.
  task automatic drive(input logic v, input pkt_s p, input logic rdy, input logic fl, input logic ie);
    fdp_dec_valid = v; cur = p; exu_ifu_ready = rdy; exu_ifu_flush = fl; int_except = ie;
    @(posedge clk); #2;
  endtask

  // Reference model: an ordered list of accepted packets, capacity DEPTH.
  always @(posedge clk) begin
    if (resetn) begin
      int  n;
      logic pu, po;
      n  = exp_q.size();
      pu = fdp_dec_valid && (n != DEPTH) && !exu_ifu_flush;
      po = (n != 0) && exu_ifu_ready && !exu_ifu_flush;
      if (exu_ifu_flush) exp_q.delete();
      else begin
        if (po) exp_q.delete(0);
        if (pu) exp_q.push_back(cur);
      end
    end
  end

  always @(negedge resetn) exp_q.delete();

  // Monitor: the DUT head must always present the model's oldest packet.
  always @(negedge clk) begin
    int n;
    n = exp_q.size();
    chk("count", 64'(dec_count), 64'(n));
    chk("fdp_ready", 64'(dec_fdp_ready), 64'(n != DEPTH));
    chk("valid", 64'(ifu_exu_valid_d), 64'(n != 0));
    if (n != 0) begin
      pkt_s h;
      h = exp_q[0];
      chk("pc", 64'(ifu_exu_pc_d), 64'(h.pc));
      chk("inst", 64'(ifu_exu_inst_d), 64'(h.inst));
      chk("br_target", 64'(ifu_exu_br_target_d), 64'(h.tgt));
      chk("br_taken", 64'(ifu_exu_br_taken_d), 64'(h.taken));
      chk("hint", 64'(ifu_exu_hint_d), 64'(h.hint));
      chk("exception", 64'(ifu_exu_exception_d), 64'(h.exc || int_except));
      chk("exccode", 64'(ifu_exu_exccode_d),
          64'(int_except ? EXC_INT_CODE : (h.exc ? h.code : 6'd0)));
    end else begin
      chk("empty_pc", 64'(ifu_exu_pc_d), 64'd0);
      chk("empty_inst", 64'(ifu_exu_inst_d), 64'd0);
      chk("empty_exc", 64'(ifu_exu_exception_d), 64'd0);
      chk("empty_code", 64'(ifu_exu_exccode_d), 64'd0);
    end
  end

  pkt_s idle;

  initial begin
    idle = mk(32'h0, 32'h0, 1'b0, 6'h0);
    resetn = 1'b0; fdp_dec_valid = 1'b0; exu_ifu_ready = 1'b0; exu_ifu_flush = 1'b0;
    int_except = 1'b0; cur = idle;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;

    // Single packet through an otherwise idle queue.
    drive(1, mk(32'h1c000000, 32'h02800c0c, 0, 0), 1, 0, 0);
    repeat (3) drive(0, idle, 1, 0, 0);

    // Six back-to-back pushes into a stalled queue, then drain.
    for (int i = 0; i < 6; i++) drive(1, mk(32'h2000 + 32'(i * 4), 32'hA000 + 32'(i), 0, 0), 0, 0, 0);
    drive(0, idle, 0, 0, 0);
    repeat (6) drive(0, idle, 1, 0, 0);

    // Streaming across the pointer wrap.
    for (int i = 0; i < 10; i++) drive(1, mk(32'(i * 4), 32'hB000 + 32'(i), 0, 0), 1, 0, 0);
    repeat (2) drive(0, idle, 1, 0, 0);

    // Interrupt tag overriding a fetch exception at the head.
    drive(1, mk(32'h3000, 32'hC000, 1, 6'h08), 0, 0, 0);
    drive(0, idle, 0, 0, 1);
    drive(0, idle, 0, 0, 0);
    drive(0, idle, 1, 0, 0);
    drive(0, idle, 0, 0, 1);

    // Flush with a concurrent push and pop offer.
    for (int i = 0; i < 3; i++) drive(1, mk(32'h4000 + 32'(i * 4), 32'hD000, 0, 0), 0, 0, 0);
    drive(1, mk(32'h4100, 32'hD100, 0, 0), 1, 1, 0);
    drive(1, mk(32'h100, 32'hE000, 0, 0), 0, 0, 0);
    drive(0, idle, 1, 0, 0);
    drive(0, idle, 1, 0, 0);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) drive(1, mk(32'h5000 + 32'(i * 4), 32'hF000, 0, 0), 0, 0, 0);
    chk("pre_reset_count", 64'(dec_count), 64'd3);
    exu_ifu_ready = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ifu_exu_valid_d), 64'd0);
    chk("async_rst_count", 64'(dec_count), 64'd0);
    chk("async_rst_ready", 64'(dec_fdp_ready), 64'd1);
    @(posedge clk); #2 resetn = 1'b1;
    drive(1, mk(32'h6000, 32'h12345678, 0, 0), 0, 0, 0);
    drive(0, idle, 1, 0, 0);
    drive(0, idle, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 9) < 7), rnd_pkt(), ($urandom_range(0, 9) < 5),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0));
    repeat (DEPTH + 2) drive(0, idle, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
